// File: rtl/dither_trunc.sv
// dither_trunc
// Pixel-depth reduction stage. It takes one byte per accepted pixel from an
// 8-bit LFSR and adds the low DROP bits as dither noise, or adds a half-LSB
// when dither is off (round-half-up). The sum saturates to all ones on
// overflow and is then truncated from IN_W to OUT_W bits. The output side is
// a two-entry skid buffer (output register + skid register), so one pixel per
// clock is sustained and s_ready can be a register.
//
// Optional feature: define DITHER_SATCNT_EN to get the sat_count port and the
// per-frame saturated-pixel counter.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    synchronous, active-low reset
//   dither_on  1: LFSR dither, 0: round-half-up (sampled per accepted beat)
//   rnd_q      current LFSR value
//   rnd_en     LFSR advance strobe, high for every accepted beat
//   s_valid / s_data / s_sof / s_eol / s_ready   input stream
//   m_valid / m_data / m_sof / m_eol / m_ready   output stream
//   sat_count  saturated-pixel count (DITHER_SATCNT_EN only)
//
// DROP = IN_W - OUT_W must lie in 1..8.
module dither_trunc #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dither_on,
  input  logic [7:0]       rnd_q,
  output logic             rnd_en,
  input  logic             s_valid,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_sof,
  input  logic             s_eol,
  output logic             s_ready,
  output logic             m_valid,
  output logic [OUT_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol,
  input  logic             m_ready
`ifdef DITHER_SATCNT_EN
  ,
  output logic [15:0]      sat_count
`endif
);

  localparam int DROP = IN_W - OUT_W;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  state_t           state_r;
  logic [OUT_W-1:0] skid_data_r;
  logic             skid_sof_r;
  logic             skid_eol_r;

  logic             accept_s;
  logic [IN_W:0]    addend_s;
  logic [IN_W:0]    sum_s;
  logic [OUT_W-1:0] new_data_s;
  logic             new_sat_s;
  logic             unused_s;

  assign accept_s = s_valid & s_ready;
  assign rnd_en   = accept_s;

  // Low sum bits are discarded by truncation and the upper LFSR bits are
  // never used as noise; fold them here so they are visibly intentional.
  assign unused_s = ^{rnd_q, sum_s[DROP-1:0], new_sat_s};

  // Dither/round, saturate and truncate the incoming pixel.
  always_comb begin
    addend_s = '0;
    if (dither_on) begin
      addend_s[DROP-1:0] = rnd_q[DROP-1:0];
    end else begin
      addend_s[DROP-1] = 1'b1;
    end
    sum_s     = {1'b0, s_data} + addend_s;
    new_sat_s = sum_s[IN_W];
    if (sum_s[IN_W]) begin
      new_data_s = '1;
    end else begin
      new_data_s = sum_s[IN_W-1:DROP];
    end
  end

  // Skid-buffer state machine with registered ready/valid and data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r     <= ST_EMPTY;
      s_ready     <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sof       <= 1'b0;
      m_eol       <= 1'b0;
      skid_data_r <= '0;
      skid_sof_r  <= 1'b0;
      skid_eol_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          s_ready <= 1'b1;
          if (accept_s) begin
            m_data  <= new_data_s;
            m_sof   <= s_sof;
            m_eol   <= s_eol;
            m_valid <= 1'b1;
            state_r <= ST_ONE;
          end else begin
            state_r <= ST_EMPTY;
          end
        end
        ST_ONE: begin
          if (accept_s && !m_ready) begin
            // Output is stalled: park the new beat in the skid register and
            // close the input one cycle after m_ready dropped.
            skid_data_r <= new_data_s;
            skid_sof_r  <= s_sof;
            skid_eol_r  <= s_eol;
            s_ready     <= 1'b0;
            state_r     <= ST_TWO;
          end else if (accept_s) begin
            m_data  <= new_data_s;
            m_sof   <= s_sof;
            m_eol   <= s_eol;
            state_r <= ST_ONE;
          end else if (m_ready) begin
            m_valid <= 1'b0;
            state_r <= ST_EMPTY;
          end else begin
            state_r <= ST_ONE;
          end
        end
        ST_TWO: begin
          if (m_ready) begin
            m_data  <= skid_data_r;
            m_sof   <= skid_sof_r;
            m_eol   <= skid_eol_r;
            s_ready <= 1'b1;
            state_r <= ST_ONE;
          end else begin
            state_r <= ST_TWO;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          s_ready <= 1'b0;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef DITHER_SATCNT_EN
  logic [15:0] sat_cnt_r;

  // Saturated-beat counter; a start-of-frame beat restarts it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sat_cnt_r <= 16'd0;
    end else if (accept_s) begin
      if (s_sof) begin
        sat_cnt_r <= {15'd0, new_sat_s};
      end else if (new_sat_s && (sat_cnt_r != 16'hFFFF)) begin
        sat_cnt_r <= sat_cnt_r + 16'd1;
      end else begin
        sat_cnt_r <= sat_cnt_r;
      end
    end else begin
      sat_cnt_r <= sat_cnt_r;
    end
  end

  assign sat_count = sat_cnt_r;
`endif

endmodule

// File: tb/tb_dither_trunc.sv
// Self-checking bench for dither_trunc: directed cases plus randomized
// traffic checked against an arithmetic reference model and a beat queue.
module tb_dither_trunc;
  localparam int IN_W  = 12;
  localparam int OUT_W = 8;
  localparam int DROP  = IN_W - OUT_W;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             dither_on;
  logic [7:0]       rnd_q;
  logic             rnd_en;
  logic             s_valid;
  logic [IN_W-1:0]  s_data;
  logic             s_sof;
  logic             s_eol;
  logic             s_ready;
  logic             m_valid;
  logic [OUT_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_ready;
`ifdef DITHER_SATCNT_EN
  logic [15:0]      sat_count;
`endif

  always #5 clk = ~clk;

  dither_trunc #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .reset_n(reset_n), .dither_on(dither_on), .rnd_q(rnd_q),
    .rnd_en(rnd_en), .s_valid(s_valid), .s_data(s_data), .s_sof(s_sof),
    .s_eol(s_eol), .s_ready(s_ready), .m_valid(m_valid), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .m_ready(m_ready)
`ifdef DITHER_SATCNT_EN
    , .sat_count(sat_count)
`endif
  );

  int         checks = 0;
  int         failures = 0;
  int         rnd_pulses = 0;
  int         exp_sat = 0;
  bit         last_rnd_en;
  logic [9:0] exp_q[$];     // {sof, eol, data}
  bit         hold_pending = 1'b0;
  logic [9:0] hold_beat;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic from the pixel rules.
  function automatic logic [9:0] model_beat(input int pix, input int rnd, input bit dith,
                                            input bit sof, input bit eol, output bit sat);
    int addend;
    int sum;
    int px;
    addend = dith ? (rnd % (1 << DROP)) : (1 << (DROP - 1));
    sum    = pix + addend;
    sat    = (sum >= (1 << IN_W));
    px     = sat ? ((1 << OUT_W) - 1) : (sum >> DROP);
    return {sof, eol, px[7:0]};
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  endfunction

  // One clock: drive at negedge, then score what the coming edge transfers.
  task automatic step(input bit v, input int d, input bit sof, input bit eol,
                      input bit dith, input int rq, input bit mr, output bit acc);
    logic [9:0] exp_b;
    bit         sat;
    @(negedge clk);
`ifdef DITHER_SATCNT_EN
    check_eq("sat_count", sat_count, exp_sat);
`endif
    if (hold_pending) begin
      check_eq("hold_valid", m_valid, 1);
      check_eq("hold_beat", {m_sof, m_eol, m_data}, hold_beat);
    end
    s_valid = v; s_data = d[IN_W-1:0]; s_sof = sof; s_eol = eol;
    dither_on = dith; rnd_q = rq[7:0]; m_ready = mr;
    #1;
    acc = s_valid && s_ready;
    last_rnd_en = rnd_en;
    check_eq("rnd_en", rnd_en, acc);
    if (rnd_en) rnd_pulses++;
    hold_pending = 1'b0;
    if (m_valid) begin
      if (mr) begin
        if (exp_q.size() == 0) begin
          check_eq("spurious_beat", m_valid, 0);
        end else begin
          exp_b = exp_q.pop_front();
          check_eq("out_beat", {m_sof, m_eol, m_data}, exp_b);
        end
      end else begin
        hold_pending = 1'b1;
        hold_beat = {m_sof, m_eol, m_data};
      end
    end
    if (acc) begin
      exp_b = model_beat(d, rq, dith, sof, eol, sat);
      exp_q.push_back(exp_b);
      if (sof) exp_sat = sat ? 1 : 0;
      else if (sat && exp_sat < 65535) exp_sat++;
    end
  endtask

  task automatic idle();
    bit acc;
    step(1'b0, 0, 1'b0, 1'b0, 1'b0, 0, 1'b1, acc);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) idle();
    idle();
    check_eq("drain_empty", exp_q.size(), 0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_m_valid", m_valid, 0);
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_m_data", m_data, 0);
    check_eq("rst_m_sof", m_sof, 0);
    check_eq("rst_m_eol", m_eol, 0);
    check_eq("rst_rnd_en", rnd_en, 0);
`ifdef DITHER_SATCNT_EN
    check_eq("rst_sat_count", sat_count, 0);
`endif
    @(negedge clk);
    reset_n = 1'b1;
    exp_q.delete(); exp_sat = 0; hold_pending = 1'b0;
    @(posedge clk); #1;
    check_eq("rel_s_ready", s_ready, 1);
    check_eq("rel_m_valid", m_valid, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit         acc;
    int         sent;
    int         p0;
    int         d;
    logic [7:0] lfsr;
    int         add_tbl[4] = '{1, 2, 4, 8};

    reset_n = 1'b0; dither_on = 1'b0; rnd_q = 8'h00; s_valid = 1'b0;
    s_data = '0; s_sof = 1'b0; s_eol = 1'b0; m_ready = 1'b0;
    apply_reset();

    // Dither sum and latency
    step(1'b1, 'h123, 1'b0, 1'b0, 1'b1, 'h01, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("lat_valid", m_valid, 1);
    check_eq("dith_a", m_data, 8'h12);
    step(1'b1, 'h12E, 1'b0, 1'b0, 1'b1, 'h02, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("dith_b", m_data, 8'h13);
    // Round-half-up
    step(1'b1, 'h127, 1'b0, 1'b0, 1'b0, 'hFF, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("round_127", m_data, 8'h12);
    step(1'b1, 'h128, 1'b0, 1'b0, 1'b0, 'hFF, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("round_128", m_data, 8'h13);
    step(1'b1, 'h000, 1'b0, 1'b0, 1'b0, 'hFF, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("round_000", m_data, 8'h00);
    // Saturation
    step(1'b1, 'hFFF, 1'b0, 1'b1, 1'b1, 'h0F, 1'b1, acc);
    @(posedge clk); #1;
    check_eq("sat_data", m_data, 8'hFF);
`ifdef DITHER_SATCNT_EN
    check_eq("sat_inc", sat_count, 1);
`endif
    drain();

    // LFSR hookup: bench LFSR advances only on the DUT's rnd_en
    lfsr = 8'h01;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 0, k == 0, k == 3, 1'b1, lfsr, 1'b1, acc);
      check_eq("lfsr_addend", lfsr[3:0], add_tbl[k]);
      if (last_rnd_en) lfsr = lfsr_next(lfsr);
    end
    drain();

    // Backpressure: 10 beats, m_ready low for cycles 3..5
    sent = 0;
    p0 = rnd_pulses;
    for (int c = 0; c < 16; c++) begin
      step(sent < 10, $urandom_range(0, 4095), sent == 0, sent == 4 || sent == 9,
           1'($urandom_range(0, 1)), $urandom_range(0, 255), !(c >= 3 && c <= 5), acc);
      if (acc) sent++;
      if (c == 3) check_eq("bp_sready_pre", s_ready, 1);
      if (c == 4) begin
        check_eq("bp_sready_fall", s_ready, 0);
        check_eq("bp_held", exp_q.size(), 2);
      end
    end
    drain();
    check_eq("bp_rnd_pulses", rnd_pulses - p0, 10);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      d = ($urandom_range(0, 3) == 0) ? $urandom_range('hFF0, 'hFFF) : $urandom_range(0, 4095);
      step(1'($urandom_range(0, 3) != 0), d, $urandom_range(0, 7) == 0,
           $urandom_range(0, 5) == 0, 1'($urandom_range(0, 1)),
           $urandom_range(0, 255), 1'($urandom_range(0, 3) != 0), acc);
    end
    drain();

    // Reset with the buffer full
    step(1'b1, 'h456, 1'b1, 1'b0, 1'b0, 0, 1'b0, acc);
    step(1'b1, 'h789, 1'b0, 1'b1, 1'b0, 0, 1'b0, acc);
    @(posedge clk); #1;
    check_eq("two_s_ready", s_ready, 0);
    check_eq("two_m_valid", m_valid, 1);
    apply_reset();
    for (int i = 0; i < 5; i++) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dither_trunc.md
# dither_trunc

Pixel-depth reduction stage that sits directly downstream of the 8-bit maximal-length LFSR random source. It consumes one LFSR byte per accepted pixel and adds the low bits as dither noise. It then saturates and truncates an IN_W-bit pixel stream to OUT_W bits. Streams on both sides use valid/ready handshakes, and the output side has a skid buffer so the stage sustains one pixel per clock under backpressure.

## Interface
- IN_W, 12: input pixel width.
- OUT_W, 8: output pixel width. DROP = IN_W-OUT_W, and DROP is required to be in 1..8.
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- dither_on  in  1  1: LFSR dither; 0: round-half-up. Sampled per accepted beat.
- rnd_q  in  8  current LFSR value.
- rnd_en  out  1  LFSR advance strobe.
- s_valid  in  1  input beat valid.
- s_data  in  IN_W  input pixel.
- s_sof  in  1  start-of-frame flag, travels with the beat.
- s_eol  in  1  end-of-line flag, travels with the beat.
- s_ready  out  1  input accept.
- m_valid  out  1  output beat valid.
- m_data  out  OUT_W  output pixel.
- m_sof  out  1  start-of-frame flag, aligned with m_data.
- m_eol  out  1  end-of-line flag, aligned with m_data.
- m_ready  in  1  downstream accept.
- sat_count  out  16  saturated-pixel count. Present only with DITHER_SATCNT_EN.

## Operation
- **Accept:** a beat is accepted when s_valid and s_ready are both high. rnd_en = s_valid & s_ready, combinational. The LFSR therefore advances exactly once per accepted pixel, and consecutive accepted beats see consecutive LFSR states.
- **Addend:** if dither_on is 1, the addend is rnd_q[DROP-1:0], zero-extended. If dither_on is 0, the addend is 1<<(DROP-1).
- **Sum:** sum = s_data + addend, computed at IN_W+1 bits.
- **Saturation:** if sum[IN_W] is 1, m_data is all ones and the beat counts as saturated. Otherwise m_data = sum[IN_W-1:DROP].
- **Flags:** s_sof and s_eol pass through unmodified, in order with their pixel.
- **Buffer states:** EMPTY, ONE (output register full), TWO (output and skid registers full).
  - EMPTY + accept → ONE.
  - ONE + accept + no m_ready → TWO; the new beat goes to the skid register.
  - ONE + accept + m_ready → ONE.
  - ONE + m_ready + no accept → EMPTY.
  - TWO + m_ready → ONE; the skid beat moves to the output register.
  - TWO + no m_ready → TWO (hold).
- **Ready and valid:** s_ready = register, high in EMPTY and ONE, low in TWO. m_valid is high in ONE and TWO.
- **Output stability:** while m_valid is high and m_ready is low, m_data, m_sof and m_eol stay stable.
- **No loss:** no beat is dropped or duplicated. Output order equals input order.

## Timing
- **Reset values:** while reset_n is low at a clock edge, the next state is m_valid=0, s_ready=0, m_data=0, m_sof=0, m_eol=0, sat_count=0, and the buffer is EMPTY. s_ready goes to 1 on the first edge with reset_n high.
- **Reset mid-transfer:** reset mid-operation discards both buffered beats. rnd_en is 0 while s_ready is 0.
- **Latency:** one cycle from the accept edge to m_valid, when in EMPTY or when ONE with m_ready high.
- **Throughput:** one beat per clock with m_ready held high.
- **s_ready fall:** when m_ready drops, s_ready falls one cycle later. Exactly one further beat is absorbed into the skid register.
- **Simultaneous events:** accept and output transfer in the same cycle in ONE keep the state at ONE, with no bubble.

## Configuration
- DITHER_SATCNT_EN defined:
  - sat_count port exists and increments on each accepted saturated beat.
  - It saturates at 0xFFFF.
  - An accepted beat with s_sof=1 loads 1 if that beat saturated, else 0.
  - It resets to 0.
- DITHER_SATCNT_EN undefined: there is no sat_count port and no counter logic. All other behaviour is identical.

## Test plan
- **Dither sum:** reset, then dither_on=1, rnd_q=0x01, s_data=0x123 → m_data=0x12 one cycle after accept. Next beat 0x12E with rnd_q=0x02 → 0x13.
- **Round-half-up:** dither_on=0. s_data=0x127 → 0x12; 0x128 → 0x13; 0x000 → 0x00.
- **Saturation:** s_data=0xFFF with rnd_q=0x0F → m_data=0xFF. With the macro defined, sat_count increments by 1.
- **Backpressure:** 10 back-to-back beats, m_ready low for 3 cycles mid-stream. Required response:
  - s_ready falls one cycle after m_ready falls.
  - Exactly 2 beats are held.
  - All 10 beats emerge in order with their sof/eol flags.
  - rnd_en pulse count is 10.
- **LFSR hookup:** connected to an LFSR reset to 0x01, 4 beats of 0x000 with dither_on=1 → dither addends are 0x1, 0x2, 0x4, 0x8. All four outputs are 0x00.
- **Reset mid-transfer:** with the buffer in TWO, pull reset_n low one cycle → m_valid=0 and s_ready=0 next cycle. s_ready=1 on the following edge, and no stale beat is emitted.
